// File: rtl/mdu_issue_ctrl_if.sv
// mdu_issue_ctrl_if: EX-stage MDU issue signals between pipeline/MDU side and the issue controller
interface mdu_issue_ctrl_if;
    logic        ex_valid;
    logic        ex_flush;
    logic [3:0]  ex_mdop;
    logic        mdu_busy;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        mdu_sel;
    logic        busy;
    logic        stall;
    logic [31:0] stall_cnt;
    logic        sync_err;
    modport master (
        output ex_valid, ex_flush, ex_mdop, mdu_busy,
        input  mdu_start, mdu_op, mdu_sel, busy, stall, stall_cnt, sync_err
    );
    modport slave (
        input  ex_valid, ex_flush, ex_mdop, mdu_busy,
        output mdu_start, mdu_op, mdu_sel, busy, stall, stall_cnt, sync_err
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: decodes EX MDU ops, drives MDU start/op/sel and stalls the front end while the unit is occupied
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            rst,
    mdu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic       md, issue;
    assign md    = bus.ex_valid && !bus.ex_flush && bus.ex_mdop inside {[4'd1:4'd8]};
    assign issue = md && state == IDLE && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (issue && bus.ex_mdop <= 4'd2) begin
                state_n = MUL;
                cnt_n   = 5'(MULT_CYCLES - 1);
            end else if (issue && bus.ex_mdop <= 4'd4) begin
                state_n = DIV;
                cnt_n   = 5'(DIV_CYCLES - 1);
            end
        end else if (cnt != 5'd0) begin
            cnt_n = cnt - 5'd1;
        end else begin
            state_n = IDLE;
        end
    end
    always_comb begin
        bus.busy      = state != IDLE;
        bus.stall     = md && state != IDLE;
        bus.mdu_start = issue && bus.ex_mdop <= 4'd4;
        bus.mdu_op    = (issue && bus.ex_mdop <= 4'd6) ? bus.ex_mdop[2:0] : 3'd0;
        bus.mdu_sel   = issue && bus.ex_mdop == 4'd8;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt <= 32'd0;
            bus.sync_err  <= 1'b0;
        end else begin
            if (bus.stall && !(&bus.stall_cnt))
                bus.stall_cnt <= bus.stall_cnt + 32'd1;
            if (bus.mdu_busy != bus.busy)
                bus.sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: two controllers (default and 2/3-cycle) driven in lockstep against a remaining-cycles model
module tb_mdu_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    mdu_issue_ctrl_if a ();
    mdu_issue_ctrl_if b ();
    mdu_issue_ctrl dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    mdu_issue_ctrl #(.MULT_CYCLES(2), .DIV_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    typedef struct packed {
        logic        start;
        logic [2:0]  op;
        logic        sel;
        logic        busy;
        logic        stall;
        logic [31:0] scnt;
        logic        serr;
    } exp_t;
    exp_t        qa[$], qb[$];
    int          rem[2]  = '{0, 0};
    logic [31:0] scnt[2] = '{0, 0};
    logic        serr[2] = '{0, 0};
    int          mc[2]   = '{5, 2};
    int          dc[2]   = '{10, 3};
    int          tests = 0, fails = 0, cycle = 0;
    task automatic cyc(input logic r, input logic v, input logic f, input logic [3:0] op, input logic frc);
        exp_t e;
        logic md, st, is, mb;
        @(posedge clk);
        #1;
        cycle++;
        rst = r;
        a.ex_valid = v; a.ex_flush = f; a.ex_mdop = op;
        b.ex_valid = v; b.ex_flush = f; b.ex_mdop = op;
        for (int i = 0; i < 2; i++) begin
            mb = frc || rem[i] > 0;
            md = v && !f && op >= 4'd1 && op <= 4'd8;
            st = md && rem[i] > 0;
            is = md && !st && !r;
            e.start = is && op <= 4'd4;
            e.op    = (is && op <= 4'd6) ? op[2:0] : 3'd0;
            e.sel   = is && op == 4'd8;
            e.busy  = rem[i] > 0;
            e.stall = st;
            e.scnt  = scnt[i];
            e.serr  = serr[i];
            if (i == 0) begin a.mdu_busy = mb; qa.push_back(e); end
            else begin b.mdu_busy = mb; qb.push_back(e); end
            if (r) begin
                rem[i] = 0; scnt[i] = 0; serr[i] = 0;
            end else begin
                if (mb != (rem[i] > 0)) serr[i] = 1'b1;
                if (st && scnt[i] != 32'hFFFF_FFFF) scnt[i] = scnt[i] + 1;
                rem[i] = (is && op <= 4'd2) ? mc[i] : (is && op <= 4'd4) ? dc[i] : (rem[i] > 0) ? rem[i] - 1 : 0;
            end
        end
    endtask
    task automatic chk(input string n, input exp_t e, input exp_t g);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got start=%0b op=%0d sel=%0b busy=%0b stall=%0b scnt=%0d serr=%0b, expected start=%0b op=%0d sel=%0b busy=%0b stall=%0b scnt=%0d serr=%0b",
                     n, cycle, g.start, g.op, g.sel, g.busy, g.stall, g.scnt, g.serr,
                     e.start, e.op, e.sel, e.busy, e.stall, e.scnt, e.serr);
        end
    endtask
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                g = '{a.mdu_start, a.mdu_op, a.mdu_sel, a.busy, a.stall, a.stall_cnt, a.sync_err};
                chk("dut_5_10", e, g);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                g = '{b.mdu_start, b.mdu_op, b.mdu_sel, b.busy, b.stall, b.stall_cnt, b.sync_err};
                chk("dut_2_3", e, g);
            end
        end
    end
    initial begin
        rst = 1'b1;
        a.ex_valid = 0; a.ex_flush = 0; a.ex_mdop = 0; a.mdu_busy = 0;
        b.ex_valid = 0; b.ex_flush = 0; b.ex_mdop = 0; b.mdu_busy = 0;
        repeat (2) @(posedge clk);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd1, 0);
        repeat (7) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd3, 0);
        repeat (11) cyc(0, 1, 0, 4'd7, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd4, 0);
        repeat (11) cyc(0, 1, 0, 4'd6, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'd2, 0);
        repeat (2) cyc(0, 1, 0, 4'd0, 0);
        repeat (4) cyc(0, 1, 1, 4'd8, 0);
        repeat (6) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 4'd9, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Issue and hazard controller for the multiply/divide unit in the EX stage. Decodes the MDU class of the instruction in EX and drives the MDU's Start/Op/Sel inputs. Tracks the unit's multi-cycle occupancy with its own occupancy counter and stalls the front end while the unit is busy. Counts stall cycles and flags any disagreement with the unit's own busy output.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu issue edge (≥2)
- DIV_CYCLES, 10, busy cycles after a div/divu issue edge (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_flush  in  1  EX instruction is being killed this cycle
- ex_mdop  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mflo, 8 mfhi, 9–15 none
- mdu_busy  in  1  Busy output of the MDU
- mdu_start  out  1  Start to MDU
- mdu_op  out  3  Op to MDU
- mdu_sel  out  1  Sel to MDU: 0 LO, 1 HI
- busy  out  1  controller occupancy (state != IDLE)
- stall  out  1  freeze IF/ID/EX, insert bubble into MEM
- stall_cnt  out  32  saturating count of stalled cycles
- sync_err  out  1  sticky: mdu_busy != busy seen

## Operation
- Internal decode, combinational: `md = ex_valid && !ex_flush && ex_mdop in 1..8`.
- States:
  - IDLE
  - MUL: a mult or multu is in progress.
  - DIV: a div or divu is in progress.
- Occupancy counter: `cnt`, 5 bits.
- `stall = md && state != IDLE`. This applies to all MDU ops, including mtlo/mthi/mflo/mfhi.
- `issue = md && !stall`.
- Outputs while issuing, combinational:
  - `mdu_op` = ex_mdop for codes 1–6, else 0.
  - `mdu_start` = issue && ex_mdop in 1..4.
  - `mdu_sel` = 1 iff ex_mdop == 8. It is 0 otherwise, including when not issuing.
- When `!issue`: `mdu_op = 0` and `mdu_start = 0`. The MDU must never see a non-zero Op while stalled.
- Transitions, at the clock edge:
  - IDLE, issue of code 1 or 2: go to MUL, `cnt ← MULT_CYCLES-1`.
  - IDLE, issue of code 3 or 4: go to DIV, `cnt ← DIV_CYCLES-1`.
  - IDLE, issue of code 5–8: stay in IDLE.
  - MUL/DIV with `cnt != 0`: decrement `cnt`.
  - MUL/DIV with `cnt == 0`: go to IDLE.
- Net effect: `busy` is high for exactly MULT_CYCLES (or DIV_CYCLES) cycles after the issue edge.
- The instruction stalled in EX issues in the first cycle in which `busy = 0`.
- `stall_cnt` increments on every cycle with `stall = 1` and holds at 0xFFFFFFFF.
- `sync_err` is set on any cycle where `mdu_busy != busy`. It is cleared only by `rst`.
- Flush: `ex_flush` suppresses decode, stall and issue in that cycle. An operation already in MUL/DIV continues to completion.
- Reset, including mid-operation:
  - `state = IDLE`, `cnt = 0`, `stall_cnt = 0`, `sync_err = 0`.
  - Outputs follow from the inputs in the same cycle; nothing issues during `rst`.

## Timing
- Reset values:
  - `busy = 0`, `stall_cnt = 0`, `sync_err = 0`.
  - `stall`, `mdu_start`, `mdu_op`, `mdu_sel`: combinational, and 0 whenever `ex_valid = 0`.
- Issue has zero latency: `mdu_start`/`mdu_op` are valid in the same cycle as EX, and the MDU samples them at that edge.
- `busy` rises at the issue edge and falls after N cycles (N = MULT_CYCLES or DIV_CYCLES). `mdu_busy` is expected to be cycle-identical.
- Back-to-back MDU ops:
  - The second op stalls exactly N cycles.
  - The second op issues in cycle N+1 after the first op's issue cycle.
- Non-MDU instructions (ex_mdop 0, 9–15) never stall, even while `busy`.
- Simultaneous flush and `busy`: no stall, no increment of `stall_cnt`.

## Test plan
- Reset, then mult (ex_mdop=1) held valid in EX:
  - issue cycle: `mdu_start=1`, `mdu_op=1`
  - `busy=1` for exactly 5 cycles
  - `mdu_busy` tracks `busy`, `sync_err=0`
- div followed immediately by mflo:
  - mflo is stalled for 10 cycles, with `mdu_op=0` and `mdu_start=0` throughout
  - mflo then issues with `mdu_sel=0`
  - `stall_cnt=10`
- divu, then mthi while busy:
  - mthi stalls until idle, then issues with `mdu_op=6`, `mdu_start=0`
  - `busy` stays 0 after the mthi issues
- mult issued, then `rst` asserted on the 3rd busy cycle:
  - next cycle `busy=0` and `stall_cnt=0`
  - a following multu issues immediately
- Flush and error flag:
  - mfhi with `ex_flush=1` during busy: `stall=0`, `stall_cnt` unchanged
  - force `mdu_busy=1` while `busy=0`: `sync_err=1` until `rst`
- Parameter override MULT_CYCLES=2, DIV_CYCLES=3: busy windows are 2 and 3 cycles.
